uart_ram_loader: RTL



---
 rtl/uart_loader_pkg.sv | 27 ++
 rtl/uart_rx_core.sv | 115 +++++++++++
 rtl/uart_ram_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART RAM loader.
//   - ld_state_e : frame-parsing FSM states
//   - rx_state_e : serial receiver states
//   - SYNC_DEFAULT, DATA_BITS : frame marker and bits per character
package uart_loader_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CKSUM
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: synchronises rxd, times bits with a down-counter and
// shifts data in LSB first.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   i_rxd           : raw serial input, idle high
//   o_byte          : last received byte (valid with o_byte_valid)
//   o_byte_valid    : 1-cycle pulse, byte received with good stop bit
//   o_byte_err      : 1-cycle pulse, stop bit was low (byte dropped)
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_byte_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_e        r_state, w_state_nx;
  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [2:0]       r_bit, w_bit_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic             r_valid, w_valid_nx;
  logic             r_err, w_err_nx;
  logic             w_rx;

  assign w_rx         = r_sync[1];
  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_byte_err   = r_err;

  // Synchroniser resets to the idle-high level so reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sync  <= {r_sync[0], i_rxd};
      r_prev  <= w_rx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_valid <= w_valid_nx;
      r_err   <= w_err_nx;
    end
  end

  // Bit timing: every sample is taken when the down-counter reaches zero
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_valid_nx = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_prev && !w_rx) begin
          w_state_nx = RX_START;
          w_cnt_nx   = CNT_W'(HALF - 1);
        end
      end
      RX_START: begin
        if (r_cnt == '0) begin
          // Mid start bit: a high line here was a glitch
          if (!w_rx) begin
            w_state_nx = RX_DATA;
            w_cnt_nx   = CNT_W'(CLKS_PER_BIT - 1);
            w_bit_nx   = '0;
          end else begin
            w_state_nx = RX_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nx = {w_rx, r_shift[7:1]};
          w_cnt_nx   = CNT_W'(CLKS_PER_BIT - 1);
          if (r_bit == 3'(DATA_BITS - 1)) w_state_nx = RX_STOP;
          else                            w_bit_nx   = r_bit + 3'd1;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (r_cnt == '0) begin
          w_valid_nx = w_rx;
          w_err_nx   = !w_rx;
          w_state_nx = RX_IDLE;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Loads host data from the debug UART into the on-chip RAM as whole words.
// Frame: SYNC, ADDR_LO, ADDR_HI, LEN (words, 0 = 256), LEN*WORD_BYTES data.
// Optional macro UART_RAM_LOADER_CKSUM_EN appends a checksum byte checked
// after the last write (two's complement of the sum of bytes after SYNC).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   rxd        : serial input, idle high
//   ram_we     : 1-cycle write strobe with ram_addr / ram_wdata
//   busy       : frame in progress
//   done       : 1-cycle pulse on successful frame end
//   frame_err  : sticky error, cleared by the next SYNC byte
module uart_ram_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned WORD_BYTES   = 4,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rxd,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [8*WORD_BYTES-1:0] ram_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_err
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;
  localparam int unsigned BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_err;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rxd       (rxd),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_byte_err  (w_byte_err)
  );

  ld_state_e         r_state, w_state_nx;
  logic [7:0]        r_alo, w_alo_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [8:0]        r_words, w_words_nx;
  logic [BC_W-1:0]   r_bcnt, w_bcnt_nx;
  logic [DATA_W-1:0] r_word, w_word_nx;
  logic              r_ram_we, w_ram_we_nx;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nx;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              r_frame_err, w_frame_err_nx;
`ifdef UART_RAM_LOADER_CKSUM_EN
  logic [7:0]        r_sum, w_sum_nx;
`endif

  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alo       <= '0;
      r_addr      <= '0;
      r_words     <= '0;
      r_bcnt      <= '0;
      r_word      <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RAM_LOADER_CKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_alo       <= w_alo_nx;
      r_addr      <= w_addr_nx;
      r_words     <= w_words_nx;
      r_bcnt      <= w_bcnt_nx;
      r_word      <= w_word_nx;
      r_ram_we    <= w_ram_we_nx;
      r_ram_addr  <= w_ram_addr_nx;
      r_ram_wdata <= w_ram_wdata_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_frame_err <= w_frame_err_nx;
`ifdef UART_RAM_LOADER_CKSUM_EN
      r_sum       <= w_sum_nx;
`endif
    end
  end

  // Frame parser and word assembler
  always_comb begin
    w_state_nx     = r_state;
    w_alo_nx       = r_alo;
    w_addr_nx      = r_addr;
    w_words_nx     = r_words;
    w_bcnt_nx      = r_bcnt;
    w_word_nx      = r_word;
    w_ram_we_nx    = 1'b0;
    w_ram_addr_nx  = r_ram_addr;
    w_ram_wdata_nx = r_ram_wdata;
    w_done_nx      = 1'b0;
    w_frame_err_nx = r_frame_err;
`ifdef UART_RAM_LOADER_CKSUM_EN
    w_sum_nx       = r_sum;
    if (w_byte_valid && (r_state inside {ST_ADDR_LO, ST_ADDR_HI, ST_LEN, ST_DATA}))
      w_sum_nx = r_sum + w_byte;
`endif
    if (w_byte_err && (r_state != ST_IDLE)) begin
      // Abort mid-frame; words already written are kept
      w_frame_err_nx = 1'b1;
      w_state_nx     = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_err) begin
            w_frame_err_nx = 1'b1;
          end else if (w_byte_valid && (w_byte == SYNC_BYTE)) begin
            w_frame_err_nx = 1'b0;
            w_state_nx     = ST_ADDR_LO;
`ifdef UART_RAM_LOADER_CKSUM_EN
            w_sum_nx       = '0;
`endif
          end
        end
        ST_ADDR_LO: begin
          if (w_byte_valid) begin
            w_alo_nx   = w_byte;
            w_state_nx = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (w_byte_valid) begin
            w_addr_nx  = ADDR_W'({w_byte, r_alo});
            w_state_nx = ST_LEN;
          end
        end
        ST_LEN: begin
          if (w_byte_valid) begin
            w_words_nx = (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
            w_bcnt_nx  = '0;
            w_state_nx = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_byte_valid) begin
            w_word_nx[8*int'(r_bcnt) +: 8] = w_byte;
            if (r_bcnt == BC_W'(WORD_BYTES - 1)) begin
              w_bcnt_nx  = '0;
              w_state_nx = ST_WRITE;
            end else begin
              w_bcnt_nx = r_bcnt + BC_W'(1);
            end
          end
        end
        ST_WRITE: begin
          w_ram_we_nx    = 1'b1;
          w_ram_addr_nx  = r_addr;
          w_ram_wdata_nx = r_word;
          w_addr_nx      = r_addr + ADDR_W'(1);
          w_words_nx     = r_words - 9'd1;
          if (r_words == 9'd1) begin
`ifdef UART_RAM_LOADER_CKSUM_EN
            w_state_nx = ST_CKSUM;
`else
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b1;
`endif
          end else begin
            w_state_nx = ST_DATA;
          end
        end
`ifdef UART_RAM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (w_byte_valid) begin
            // Running sum plus its two's complement must wrap to zero
            if (8'(w_byte + r_sum) == 8'd0) w_done_nx      = 1'b1;
            else                           w_frame_err_nx = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
`endif
        default: w_state_nx = ST_IDLE;
      endcase
    end
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

endmodule
